d_memory_model: RTL and testbench



---
 rtl/d_memory_model_pkg.sv | 22 ++
 rtl/d_memory_model_array.sv | 43 ++++
 rtl/d_memory_model.sv | 144 ++++++++++++++
 tb/tb_d_memory_model.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/d_memory_model_pkg.sv
// -----------------------------------------------------------------------------
// d_memory_model_pkg
//   Shared core types and constants for the data-side memory path.
//   - memory_op_t           : request operation encoding (LOAD / STORE).
//   - D_MEMORY_ADDR_WIDTH   : width of the byte address on the memory port.
//   - REG_VAL_WIDTH         : width of one data word / register value.
//   - D_MEM_DEFAULT_LATENCY : default request-to-ack latency of d_memory_model.
// -----------------------------------------------------------------------------
package d_memory_model_pkg;

  localparam int unsigned D_MEMORY_ADDR_WIDTH   = 32;
  localparam int unsigned REG_VAL_WIDTH         = 32;
  localparam int unsigned D_MEM_DEFAULT_LATENCY = 3;

  // Two bits wide so the spare encodings exist; they complete with data 0
  // and never write.
  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    STORE = 2'b01
  } memory_op_t;

endpackage : d_memory_model_pkg

// File: rtl/d_memory_model_array.sv
// -----------------------------------------------------------------------------
// d_mem_array
//   Word array with synchronous write and asynchronous (combinational) read.
//   Every word is cleared while reset is asserted.
//
//   Ports:
//     clk    in   write clock
//     reset  in   asynchronous active-high clear of all words
//     we     in   write enable, takes effect at the rising edge
//     addr   in   word index for both read and write
//     wdata  in   write data
//     rdata  out  read data for addr (combinational)
// -----------------------------------------------------------------------------
module d_mem_array #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is reset on purpose: a freshly reset memory must read as
  // all zeros. This rules out block-RAM mapping, which is acceptable for a
  // behavioural model; a RAM-backed array would simply drop this reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule : d_mem_array

// File: rtl/d_memory_model.sv
// -----------------------------------------------------------------------------
// d_memory_model
//   Cycle-accurate data memory behind the LSU memory controller. It accepts
//   one request at a time and acks it LATENCY cycles after acceptance. Loads
//   return the addressed word with the ack. Stores write at the end of the
//   ack cycle.
//
//   Parameters:
//     LATENCY  cycles from acceptance to ack (1..15)
//     DEPTH    number of REG_VAL_WIDTH-bit words (power of two)
//
//   Ports:
//     clk                 in   single clock, rising edge
//     reset               in   asynchronous active-high reset
//     memory_req_valid    in   request present
//     memory_req_op       in   LOAD / STORE
//     memory_req_address  in   byte address (offset bits ignored, wraps)
//     memory_req_data     in   store data
//     memory_ready        out  request can be accepted this cycle
//     memory_ack          out  one-cycle completion pulse
//     memory_data_return  out  load data, zero unless acking a LOAD
// -----------------------------------------------------------------------------
module d_memory_model
  import d_memory_model_pkg::*;
#(
  parameter int unsigned LATENCY = D_MEM_DEFAULT_LATENCY,
  parameter int unsigned DEPTH   = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           memory_req_valid,
  input  memory_op_t                     memory_req_op,
  input  logic [D_MEMORY_ADDR_WIDTH-1:0] memory_req_address,
  input  logic [REG_VAL_WIDTH-1:0]       memory_req_data,
  output logic                           memory_ready,
  output logic                           memory_ack,
  output logic [REG_VAL_WIDTH-1:0]       memory_data_return
);

  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam int unsigned BYTE_OFF_W = $clog2(REG_VAL_WIDTH / 8);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("d_memory_model: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  state_t                   state, next_state;
  logic [3:0]               count;
  memory_op_t               op_q;
  logic [IDX_W-1:0]         idx_q;
  logic [REG_VAL_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]         req_idx;
  logic [REG_VAL_WIDTH-1:0] rd_data;
  logic                     accept;
  logic                     mem_we;

  // Drop the byte-offset bits, then keep only the index bits so that upper
  // address bits alias onto the array.
  assign req_idx = IDX_W'(memory_req_address >> BYTE_OFF_W);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of the order the processes are evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state         = state;
    accept             = 1'b0;
    mem_we             = 1'b0;
    memory_ready       = 1'b0;
    memory_ack         = 1'b0;
    memory_data_return = '0;
    case (state)
      IDLE: begin
        memory_ready = 1'b1;
        if (memory_req_valid) begin
          accept     = 1'b1;
          next_state = (LATENCY == 1) ? ACK : BUSY;
        end
      end
      BUSY: begin
        // count is loaded with LATENCY-1 at acceptance, so leaving BUSY at
        // count==1 lands the ack exactly LATENCY cycles after acceptance.
        if (count == 4'd1) begin
          next_state = ACK;
        end
      end
      ACK: begin
        memory_ack = 1'b1;
        next_state = IDLE;
        if (op_q == LOAD) begin
          memory_data_return = rd_data;
        end else if (op_q == STORE) begin
          mem_we = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request capture and latency counter. The requester does not hold the
  // request after acceptance, so everything needed later is stored here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      op_q   <= LOAD;
      idx_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      count  <= 4'(LATENCY - 1);
      op_q   <= memory_req_op;
      idx_q  <= req_idx;
      data_q <= memory_req_data;
    end else if (state == BUSY) begin
      count <= count - 4'd1;
    end
  end

  d_mem_array #(
    .WIDTH (REG_VAL_WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .addr  (idx_q),
    .wdata (data_q),
    .rdata (rd_data)
  );

endmodule : d_memory_model

// File: tb/tb_d_memory_model.sv
// -----------------------------------------------------------------------------
// tb_d_memory_model
//   Two instances share clock and reset: dut0 with LATENCY=3, dut1 with
//   LATENCY=1. A reference model tracks each instance as "pending request
//   with N cycles left" plus a plain word array, and every cycle the outputs
//   of both instances are compared against it on the falling edge.
// -----------------------------------------------------------------------------
module tb_d_memory_model;
  import d_memory_model_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT0  = 3;
  localparam int LAT1  = 1;

  logic                           clk = 1'b0;
  logic                           reset;
  logic [1:0]                     v;
  memory_op_t                     op   [2];
  logic [D_MEMORY_ADDR_WIDTH-1:0] addr [2];
  logic [REG_VAL_WIDTH-1:0]       wd   [2];
  logic [1:0]                     rdy;
  logic [1:0]                     ack;
  logic [REG_VAL_WIDTH-1:0]       rd   [2];

  always #5 clk = ~clk;

  d_memory_model #(.LATENCY(LAT0), .DEPTH(DEPTH)) dut0 (
    .clk                (clk),
    .reset              (reset),
    .memory_req_valid   (v[0]),
    .memory_req_op      (op[0]),
    .memory_req_address (addr[0]),
    .memory_req_data    (wd[0]),
    .memory_ready       (rdy[0]),
    .memory_ack         (ack[0]),
    .memory_data_return (rd[0])
  );

  d_memory_model #(.LATENCY(LAT1), .DEPTH(DEPTH)) dut1 (
    .clk                (clk),
    .reset              (reset),
    .memory_req_valid   (v[1]),
    .memory_req_op      (op[1]),
    .memory_req_address (addr[1]),
    .memory_req_data    (wd[1]),
    .memory_ready       (rdy[1]),
    .memory_ack         (ack[1]),
    .memory_data_return (rd[1])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          lat    [2];
  bit          m_busy [2];
  int          m_left [2];   // cycles remaining until the ack cycle
  bit          m_acc  [2];   // request accepted at the most recent edge
  memory_op_t  m_op   [2];
  int          m_idx  [2];
  logic [31:0] m_data [2];
  logic [31:0] m_mem  [2][DEPTH];

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_acc[k]  = 1'b0;
      m_left[k] = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 1'b0;
      if (m_busy[k]) begin
        if (m_left[k] == 0) begin
          if (m_op[k] == STORE) m_mem[k][m_idx[k]] = m_data[k];
          m_busy[k] = 1'b0;
        end else begin
          m_left[k]--;
        end
      end else if (v[k]) begin
        m_busy[k] = 1'b1;
        m_acc[k]  = 1'b1;
        m_left[k] = lat[k] - 1;
        m_op[k]   = op[k];
        m_idx[k]  = word_of(addr[k]);
        m_data[k] = wd[k];
      end
    end
  endtask

  task automatic compare();
    logic        e_ack;
    logic [31:0] e_data;
    for (int k = 0; k < 2; k++) begin
      e_ack  = m_busy[k] && (m_left[k] == 0);
      e_data = (e_ack && m_op[k] == LOAD) ? m_mem[k][m_idx[k]] : 32'h0;
      check($sformatf("dut%0d.ready", k), {31'h0, rdy[k]}, {31'h0, !m_busy[k]});
      check($sformatf("dut%0d.ack", k),   {31'h0, ack[k]}, {31'h0, e_ack});
      check($sformatf("dut%0d.data", k),  rd[k], e_data);
    end
  endtask

  // One clock: model follows the edge, outputs are checked on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    @(negedge clk);
    compare();
  endtask

  // Present a request on instance k until accepted, then wait for its ack.
  task automatic run_req(input int k, input memory_op_t o, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] got, output int lat_seen);
    int n;
    op[k] = o; addr[k] = a; wd[k] = d; v[k] = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!m_acc[k] && n < 50);
    v[k] = 1'b0;
    lat_seen = 1;
    while (!ack[k] && lat_seen < 50) begin cycle(); lat_seen++; end
    check($sformatf("dut%0d.ack_seen", k), {31'h0, ack[k]}, 32'h1);
    got = rd[k];
    cycle();
  endtask

  logic [31:0] got;
  int          ls;
  int          n;
  int          r;

  initial begin
    lat[0] = LAT0;
    lat[1] = LAT1;
    v = '0;
    for (int k = 0; k < 2; k++) begin
      op[k] = LOAD; addr[k] = '0; wd[k] = '0;
    end
    reset = 1'b1;
    model_reset();
    repeat (3) cycle();
    reset = 1'b0;
    cycle();

    // Reset/idle state explicitly.
    check("rst.ready", {30'h0, rdy}, 32'h3);
    check("rst.ack",   {30'h0, ack}, 32'h0);

    // Load of never-written word after reset.
    run_req(0, LOAD, 32'h40, 32'h0, got, ls);
    check("load40.data", got, 32'h0);
    check("load40.latency", ls, LAT0);

    // Store then load same address.
    run_req(0, STORE, 32'h100, 32'hDEADBEEF, got, ls);
    check("store100.latency", ls, LAT0);
    check("store100.data", got, 32'h0);
    run_req(0, LOAD, 32'h100, 32'h0, got, ls);
    check("load100.data", got, 32'hDEADBEEF);

    // Back-to-back: valid held high, second request waits for ready.
    op[0] = STORE; addr[0] = 32'h8; wd[0] = 32'h11; v[0] = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!m_acc[0] && n < 50);
    op[0] = LOAD; wd[0] = 32'h0;
    n = 0;
    do begin cycle(); n++; end while (!m_acc[0] && n < 50);
    check("b2b.spacing", n, LAT0 + 1);
    v[0] = 1'b0;
    n = 1;
    while (!ack[0] && n < 50) begin cycle(); n++; end
    check("b2b.ack_seen", {31'h0, ack[0]}, 32'h1);
    check("b2b.data", rd[0], 32'h11);
    cycle();

    // Address wrap and ignored byte offset.
    run_req(0, STORE, 32'h1004, 32'hA5, got, ls);
    run_req(0, LOAD, 32'h4, 32'h0, got, ls);
    check("wrap.load4", got, 32'hA5);
    run_req(0, LOAD, 32'h7, 32'h0, got, ls);
    check("wrap.load7", got, 32'hA5);

    // LATENCY=1 instance.
    run_req(1, STORE, 32'h40, 32'h1234_5678, got, ls);
    run_req(1, LOAD, 32'h40, 32'h0, got, ls);
    check("lat1.latency", ls, LAT1);
    check("lat1.data", got, 32'h1234_5678);
    check("lat1.ready_after", {31'h0, rdy[1]}, 32'h1);

    // Reset in the middle of a store: no ack, no write.
    op[0] = STORE; addr[0] = 32'h20; wd[0] = 32'h55; v[0] = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!m_acc[0] && n < 50);
    v[0] = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    cycle();
    check("midrst.ack", {31'h0, ack[0]}, 32'h0);
    cycle();
    reset = 1'b0;
    repeat (LAT0 + 1) cycle();
    run_req(0, LOAD, 32'h20, 32'h0, got, ls);
    check("midrst.load20", got, 32'h0);

    // Randomised traffic on both instances, with occasional resets.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        v[k] = 1'($urandom_range(0, 1));
        r = int'($urandom_range(0, 7));
        if (r == 0)          op[k] = memory_op_t'(2'b10);
        else if (r == 1)     op[k] = memory_op_t'(2'b11);
        else if (r % 2 == 0) op[k] = STORE;
        else                 op[k] = LOAD;
        addr[k] = $urandom & 32'h0000_F01F;
        wd[k]   = $urandom;
      end
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 1'b1;
        model_reset();
        cycle();
        reset = 1'b0;
      end else begin
        cycle();
      end
    end
    v = '0;
    repeat (LAT0 + 2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_d_memory_model
